dcache_wb_reader: RTL and testbench

DCACHE_WB_READER -- requirements
Module: dcache_wb_reader

---
 rtl/dcache_wb_reader.sv | 119 +++++++++++
 tb/tb_dcache_wb_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb_reader.sv
`default_nettype none
// ============================================================================
// dcache_wb_reader : streams a line RAM out as little-endian 32-bit bus words
// Optional macro DCACHE_WB_CLEAR_EN zeroes each byte as it is read. Rev 1.0
// ============================================================================
module dcache_wb_reader #(
  parameter int ADDRBITS = 5,
  parameter int DATABITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [ADDRBITS-1:0] ram_addr,
  input  logic [DATABITS-1:0] ram_rdata,
  output logic                ram_we,
  output logic [DATABITS-1:0] ram_wdata,
  output logic                bus_valid,
  input  logic                bus_ready,
  output logic [31:0]         bus_data,
  output logic                bus_last
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDRBITS-1:0] cnt_q, cnt_d;
  logic [31:0]         data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        data_d[{cnt_q[1:0], 3'b000} +: 8] = ram_rdata;
        cnt_d = cnt_q + ADDRBITS'(1);
        if (cnt_q[1:0] == 2'd3) state_d = S_SEND;
      end
      S_SEND: begin
        if (bus_ready) state_d = last_q ? S_DONE : S_FETCH;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state; the counter has wrapped to 0
    // exactly when the final word of the line has been fetched.
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    valid_d = (state_d == S_SEND);
    last_d  = (state_d == S_SEND) && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

`ifdef DCACHE_WB_CLEAR_EN
  // Write lands on the same edge the byte is captured, so the read sees old data.
  logic we_q, we_d;

  always_comb begin
    we_d = (state_d == S_FETCH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) we_q <= 1'b0;
    else          we_q <= we_d;
  end

  assign ram_we    = we_q;
  assign ram_wdata = '0;
`else
  assign ram_we    = 1'b0;
  assign ram_wdata = '0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign ram_addr  = cnt_q;
  assign bus_valid = valid_q;
  assign bus_data  = data_q;
  assign bus_last  = last_q;

endmodule
`default_nettype wire

// File: tb/tb_dcache_wb_reader.sv
`default_nettype none
// ============================================================================
// tb_dcache_wb_reader : table-driven, scoreboarded bench for dcache_wb_reader
// Honours DCACHE_WB_CLEAR_EN when checking RAM contents. Rev 1.0
// ============================================================================
module tb_dcache_wb_reader;

  localparam int ADDRBITS = 5;
  localparam int NBYTES   = 32;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic                busy, done;
  logic [ADDRBITS-1:0] ram_addr;
  logic [7:0]          ram_rdata;
  logic                ram_we;
  logic [7:0]          ram_wdata;
  logic                bus_valid;
  logic                bus_ready = 1'b1;
  logic [31:0]         bus_data;
  logic                bus_last;

  dcache_wb_reader #(.ADDRBITS(ADDRBITS), .DATABITS(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_data  (bus_data),
    .bus_last  (bus_last)
  );

  always #5 clk = ~clk;

  // Line RAM model: combinational read, write on clock edge, bulk load on request.
  logic [7:0] mem [0:NBYTES-1];
  logic       load_req = 1'b0;
  logic [7:0] load_base = 8'h00;
  assign ram_rdata = mem[ram_addr];

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < NBYTES; i++) mem[i] <= load_base + 8'(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  int we_count = 0;
  always @(negedge clk) if (ram_we === 1'b1) we_count = we_count + 1;

  typedef struct {
    logic [7:0]  base;
    int          stall_word;
    int          stall_len;
    bit          repulse;
    logic [31:0] exp_first;
    logic [31:0] exp_stall;
    logic [31:0] exp_last;
    int          exp_done_cyc;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  vec_t vecs [4];
  exp_t sbq [$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_ram(input logic [7:0] base);
    @(negedge clk);
    load_base = base;
    load_req  = 1'b1;
    @(negedge clk);
    load_req  = 1'b0;
  endtask

  task automatic run_line(input int vi);
    vec_t v;
    exp_t e;
    int   cyc, widx, stall_left, done_cnt, first_cyc, last_cyc, done_cyc, bad, we0;
    v = vecs[vi];
    load_ram(v.base);
    sbq.delete();
    for (int w = 0; w < 8; w++) begin
      e.data = {8'(v.base + 4*w + 3), 8'(v.base + 4*w + 2),
                8'(v.base + 4*w + 1), 8'(v.base + 4*w)};
      e.last = (w == 7);
      sbq.push_back(e);
    end
    we0 = we_count;
    start = 1'b1; bus_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; widx = 0; stall_left = v.stall_len; done_cnt = 0;
    first_cyc = -1; last_cyc = -1; done_cyc = -1;
    while (cyc < 120 && !(done_cyc > 0 && cyc > done_cyc + 2)) begin
      start     = v.repulse && (cyc == 2 || cyc == 5);
      bus_ready = 1'b1;
      if (bus_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (widx == v.stall_word && stall_left > 0) begin
          bus_ready = 1'b0;
          stall_left--;
          check("stall_data", bus_data, v.exp_stall);
          check("stall_addr", 32'(ram_addr), 32'((4 * (widx + 1)) % NBYTES));
          check("stall_last", 32'(bus_last), 32'(widx == 7));
        end else begin
          if (sbq.size() == 0) begin
            check("extra_word", bus_data, 32'hxxxx_xxxx);
          end else begin
            e = sbq.pop_front();
            check("word_data", bus_data, e.data);
            check("word_last", 32'(bus_last), 32'(e.last));
            if (widx == 0) check("first_word", bus_data, v.exp_first);
            if (e.last) begin
              last_cyc = cyc;
              check("last_word", bus_data, v.exp_last);
            end
          end
          widx++;
        end
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        check("done_addr", 32'(ram_addr), 32'd0);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
    check("first_valid_cyc", 32'(first_cyc), 32'd5);
    check("last_cyc", 32'(last_cyc), 32'(v.exp_done_cyc - 1));
    check("done_cyc", 32'(done_cyc), 32'(v.exp_done_cyc));
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("words_left", 32'(sbq.size()), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_addr", 32'(ram_addr), 32'd0);
    bad = 0;
    for (int i = 0; i < NBYTES; i++) begin
`ifdef DCACHE_WB_CLEAR_EN
      if (mem[i] !== 8'h00) bad++;
`else
      if (mem[i] !== v.base + 8'(i)) bad++;
`endif
    end
    check("ram_contents_bad", 32'(bad), 32'd0);
`ifdef DCACHE_WB_CLEAR_EN
    check("ram_we_cycles", 32'(we_count - we0), 32'd32);
`else
    check("ram_we_cycles", 32'(we_count - we0), 32'd0);
`endif
  endtask

  task automatic reset_midword();
    load_ram(8'h00);
    start = 1'b1; bus_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    // Now in the second FETCH cycle of the fourth word.
    check("busy_before_rst", 32'(busy), 32'd1);
    check("data_before_rst", bus_data, 32'h0B0A_090C);
    reset_n = 1'b0;
    #1;
    check("rst_ctrl", 32'({busy, done, bus_valid, bus_last, ram_we}), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_bus_data", bus_data, 32'd0);
    check("rst_wdata", 32'(ram_wdata), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_rst", 32'({busy, bus_valid, done}), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'h00, -1,  0, 1'b0, 32'h0302_0100, 32'h0000_0000, 32'h1F1E_1D1C, 41};
    vecs[1] = '{8'h00,  2, 10, 1'b0, 32'h0302_0100, 32'h0B0A_0908, 32'h1F1E_1D1C, 51};
    vecs[2] = '{8'h40, -1,  0, 1'b1, 32'h4342_4140, 32'h0000_0000, 32'h5F5E_5D5C, 41};
    vecs[3] = '{8'h80,  7,  3, 1'b0, 32'h8382_8180, 32'h9F9E_9D9C, 32'h9F9E_9D9C, 44};

    repeat (3) @(negedge clk);
    check("reset_ctrl", 32'({busy, done, bus_valid, bus_last, ram_we}), 32'd0);
    check("reset_addr", 32'(ram_addr), 32'd0);
    check("reset_bus_data", bus_data, 32'd0);
    check("reset_wdata", 32'(ram_wdata), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_busy_init", 32'(busy), 32'd0);

    for (int i = 0; i < 4; i++) run_line(i);

    reset_midword();
    run_line(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
